// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides and collapsing bubbles.
// Optional: define ADD_PIPE_SAT_EN to clamp a-b to zero when a < b.
module add_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
);

  logic [STAGES:1]            r_v;
  logic [STAGES:1][WIDTH:0]   r_d;
  logic [STAGES:1]            w_load;
  logic [WIDTH:0]             w_res;

  always_comb begin
    w_res = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
`ifdef ADD_PIPE_SAT_EN
    if (sub && (a < b)) w_res = '0;
`else
`endif
  end

  // A stage can load if any stage at or after it is empty, or the output drains.
  // Written flat rather than as a chain so there is no combinational self-reference.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      w_load[k] = out_ready;
      for (int j = k; j <= STAGES; j++)
        if (!r_v[j]) w_load[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      if (w_load[1]) begin
        r_v[1] <= in_valid;
        if (in_valid) r_d[1] <= w_res;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) r_d[k] <= r_d[k-1];
        end
      end
    end
  end

  assign in_ready  = !rst && w_load[1];
  assign out_valid = r_v[STAGES];
  assign sum       = r_d[STAGES];

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: directed scenarios plus random traffic against a queue model.
module tb_add_pipe;
  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [W:0]   sum;

  int         checks = 0;
  int         errors = 0;
  logic [W:0] q[$];
  bit         prev_stall = 1'b0;
  logic [W:0] prev_sum;
  bit         acc;
  int         nacc;

  add_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_op(int x, int y, bit s);
    int r;
    if (!s)          r = x + y;
    else if (x >= y) r = x - y;
    else begin
`ifdef ADD_PIPE_SAT_EN
      r = 0;
`else
      r = x - y + (1 << (W + 1));
`endif
    end
    return r[W:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the handshake/output against the model, then advance the edge.
  task automatic cyc();
    bit         exp_rdy;
    logic [W:0] e;
    #1;
    if (prev_stall) begin
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_sum", {27'b0, sum}, {27'b0, prev_sum});
    end
    exp_rdy = !rst && ((q.size() < S) || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = in_valid && exp_rdy;
    if (rst) q.delete();
    else begin
      if (out_valid === 1'b1) chk("valid_has_data", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("sum", {27'b0, sum}, {27'b0, e});
      end
      if (acc) q.push_back(ref_op(int'(a), int'(b), sub));
    end
    prev_stall = !rst && (out_valid === 1'b1) && !out_ready;
    prev_sum   = sum;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int x, input int y, input bit s);
    in_valid = v; a = x[W-1:0]; b = y[W-1:0]; sub = s;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    drive(1, 3, 4, 0);
    @(posedge clk); #1;

    // Reset held two cycles with in_valid high
    cyc(); cyc();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", {27'b0, sum}, 32'd0);
    rst = 1'b0; drive(0, 0, 0, 0); out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
    end

    // Streaming add, latency and back-to-back results
    drive(1, 1, 5, 0);   cyc();
    chk("lat_stage1", {31'b0, out_valid}, 32'd0);
    drive(1, 15, 15, 0); cyc();
    chk("lat_first_valid", {31'b0, out_valid}, 32'd1);
    chk("add_1_5", {27'b0, sum}, 32'd6);
    drive(0, 0, 0, 0);   cyc();
    chk("stream_valid", {31'b0, out_valid}, 32'd1);
    chk("add_15_15", {27'b0, sum}, 32'd30);
    cyc();
    chk("stream_empty", {31'b0, out_valid}, 32'd0);

    // Subtraction with and without borrow
    drive(1, 3, 5, 1); cyc();
    drive(1, 9, 4, 1); cyc();
`ifdef ADD_PIPE_SAT_EN
    chk("sub_3_5", {27'b0, sum}, 32'd0);
`else
    chk("sub_3_5", {27'b0, sum}, 32'd30);
`endif
    drive(0, 0, 0, 0); cyc();
    chk("sub_9_4", {27'b0, sum}, 32'd5);
    cyc();

    // Backpressure: three offers, only two fit
    out_ready = 1'b0; nacc = 0;
    drive(1, 2, 3, 0);  cyc(); nacc += int'(acc);
    drive(1, 7, 1, 1);  cyc(); nacc += int'(acc);
    drive(1, 12, 6, 0);
    for (int i = 0; i < 3; i++) begin cyc(); nacc += int'(acc); end
    chk("bp_accepted", nacc, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_frozen_sum", {27'b0, sum}, 32'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && nacc < 3; i++) begin cyc(); nacc += int'(acc); end
    chk("bp_third_in", nacc, 32'd3);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc();
    chk("bp_drained", q.size(), 32'd0);

    // Simultaneous in/out on a full pipeline
    out_ready = 1'b0;
    drive(1, 4, 4, 0); cyc();
    drive(1, 8, 2, 1); cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      #1;
      chk("full_out_valid", {31'b0, out_valid}, 32'd1);
      chk("full_in_ready", {31'b0, in_ready}, 32'd1);
      cyc();
      chk("full_occupancy", q.size(), S);
    end

    // Reset mid-flight discards both results
    drive(0, 0, 0, 0); out_ready = 1'b0; cyc();
    rst = 1'b1; cyc();
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("midrst_gone", {31'b0, out_valid}, 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drive(0, 0, 0, 0); out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
    chk("rand_drained", q.size(), 32'd0);
    cyc();
    chk("final_idle", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
